// File: rtl/word_list_sender.sv
// Splits a word_list payload byte stream into words (ranges + chars) and hands each to the word generator,
// then a terminating dummy word; word_wr_en rises the cycle after the completing byte, bytes stall (full) while a word is pending.
module word_list_sender #(
    parameter int CHAR_BITS      = 7,
    parameter int RANGES_MAX     = 2,
    parameter int WORD_MAX_LEN   = 8,
    parameter int RANGE_INFO_MSB = $clog2(WORD_MAX_LEN)
) (
    input  logic                                    CLK,
    input  logic                                    rst,
    input  logic [7:0]                              din,
    input  logic                                    wr_en,
    input  logic                                    inpkt_end,
    output logic                                    full,
    output logic [WORD_MAX_LEN*CHAR_BITS-1:0]       word_out,
    output logic [RANGES_MAX*(RANGE_INFO_MSB+1)-1:0] range_info,
    output logic [15:0]                             word_id,
    output logic                                    word_list_end,
    output logic                                    word_wr_en,
    input  logic                                    word_full,
    output logic                                    err_word_list
);
    localparam int FW  = RANGE_INFO_MSB + 1;
    localparam int WW  = WORD_MAX_LEN * CHAR_BITS;
    localparam int RIW = RANGES_MAX * FW;
    localparam int RCW = (RANGES_MAX > 1) ? $clog2(RANGES_MAX) : 1;
    localparam int CCW = (WORD_MAX_LEN > 1) ? $clog2(WORD_MAX_LEN) : 1;

    typedef enum logic [2:0] {
        ST_RANGE,
        ST_CHARS,
        ST_SEND,
        ST_SEND_END,
        ST_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [RCW-1:0]  range_cnt_q, range_cnt_d;
    logic [CCW-1:0]  char_cnt_q, char_cnt_d;
    logic [WW-1:0]   word_q, word_d;
    logic [RIW-1:0]  range_q, range_d;
    logic [15:0]     word_id_q, word_id_d;
    logic            pkt_last_q, pkt_last_d;

    logic            byte_acc;
    logic            word_acc;
    logic [FW-1:0]   field;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RANGE;
            range_cnt_q <= '0;
            char_cnt_q  <= '0;
            word_q      <= '0;
            range_q     <= '0;
            word_id_q   <= '0;
            pkt_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            range_cnt_q <= range_cnt_d;
            char_cnt_q  <= char_cnt_d;
            word_q      <= word_d;
            range_q     <= range_d;
            word_id_q   <= word_id_d;
            pkt_last_q  <= pkt_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        range_cnt_d = range_cnt_q;
        char_cnt_d  = char_cnt_q;
        word_d      = word_q;
        range_d     = range_q;
        word_id_d   = word_id_q;
        pkt_last_d  = pkt_last_q;
        field       = '0;

        full     = (state_q == ST_SEND) || (state_q == ST_SEND_END) || (state_q == ST_ERROR);
        byte_acc = wr_en && !full;
        word_acc = word_wr_en && !word_full;

        case (state_q)
            ST_RANGE: begin
                if (byte_acc) begin
                    // Position is checked on the full 7-bit field so out-of-range values are not masked by truncation.
                    if (inpkt_end) begin
                        state_d = ST_ERROR;
                    end else if (din[7] && (din[6:0] > 7'(WORD_MAX_LEN - 1))) begin
                        state_d = ST_ERROR;
                    end else begin
                        if (din[7]) begin
                            field = {1'b1, din[RANGE_INFO_MSB-1:0]};
                        end
                        for (int i = 0; i < RANGES_MAX; i++) begin
                            if (range_cnt_q == RCW'(i)) begin
                                range_d[i*FW +: FW] = field;
                            end
                        end
                        if (range_cnt_q == RCW'(RANGES_MAX - 1)) begin
                            range_cnt_d = '0;
                            char_cnt_d  = '0;
                            word_d      = '0;
                            state_d     = ST_CHARS;
                        end else begin
                            range_cnt_d = range_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_CHARS: begin
                if (byte_acc) begin
                    if (din == 8'h00) begin
                        pkt_last_d = inpkt_end;
                        state_d    = ST_SEND;
                    end else if ((CHAR_BITS == 7) && din[7]) begin
                        state_d = ST_ERROR;
                    end else begin
                        for (int i = 0; i < WORD_MAX_LEN; i++) begin
                            if (char_cnt_q == CCW'(i)) begin
                                word_d[i*CHAR_BITS +: CHAR_BITS] = din[CHAR_BITS-1:0];
                            end
                        end
                        // A full-length word completes on its last char; no terminator is expected.
                        if (char_cnt_q == CCW'(WORD_MAX_LEN - 1)) begin
                            pkt_last_d = inpkt_end;
                            state_d    = ST_SEND;
                        end else if (inpkt_end) begin
                            state_d = ST_ERROR;
                        end else begin
                            char_cnt_d = char_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_SEND: begin
                if (word_acc) begin
                    word_id_d = word_id_q + 16'd1;
                    state_d   = pkt_last_q ? ST_SEND_END : ST_RANGE;
                end
            end
            ST_SEND_END: begin
                if (word_acc) begin
                    word_id_d  = '0;
                    pkt_last_d = 1'b0;
                    state_d    = ST_RANGE;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

    // Outputs decode straight from state so an async reset drops word_wr_en immediately.
    assign word_wr_en    = (state_q == ST_SEND) || (state_q == ST_SEND_END);
    assign word_list_end = (state_q == ST_SEND_END);
    assign err_word_list = (state_q == ST_ERROR);
    assign word_out      = (state_q == ST_SEND_END) ? '0 : word_q;
    assign range_info    = (state_q == ST_SEND_END) ? '0 : range_q;
    assign word_id       = word_id_q;

endmodule

// File: tb/tb_word_list_sender.sv
// Directed bench for word_list_sender with default parameters (7-bit chars, 2 ranges, 8-char words).
module tb_word_list_sender;
    logic        CLK = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        wr_en;
    logic        inpkt_end;
    logic        full;
    logic [55:0] word_out;
    logic [7:0]  range_info;
    logic [15:0] word_id;
    logic        word_list_end;
    logic        word_wr_en;
    logic        word_full;
    logic        err_word_list;

    int checks = 0;
    int errors = 0;

    word_list_sender #(
        .CHAR_BITS(7),
        .RANGES_MAX(2),
        .WORD_MAX_LEN(8),
        .RANGE_INFO_MSB(3)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .din(din),
        .wr_en(wr_en),
        .inpkt_end(inpkt_end),
        .full(full),
        .word_out(word_out),
        .range_info(range_info),
        .word_id(word_id),
        .word_list_end(word_list_end),
        .word_wr_en(word_wr_en),
        .word_full(word_full),
        .err_word_list(err_word_list)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic do_reset;
        rst = 1'b1; wr_en = 1'b0; inpkt_end = 1'b0; din = 8'h00; word_full = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        din = b; inpkt_end = last; wr_en = 1'b1;
        while (full && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL send_byte_%h: full=%b after %0d cycles, required 0", b, full, n);
        end
        @(posedge CLK); #1;
        wr_en = 1'b0; inpkt_end = 1'b0;
    endtask

    task automatic expect_word(input string nm, input logic [55:0] w, input logic [7:0] r,
                               input logic [15:0] id, input logic e);
        int n;
        n = 0;
        while (!word_wr_en && n < 20) begin
            @(posedge CLK); #1; n++;
        end
        checks++;
        if (word_wr_en !== 1'b1 || word_out !== w || range_info !== r || word_id !== id || word_list_end !== e) begin
            errors++;
            $display("FAIL %s: vld=%b word=%h range=%h id=%0d end=%b, required vld=1 word=%h range=%h id=%0d end=%b",
                     nm, word_wr_en, word_out, range_info, word_id, word_list_end, w, r, id, e);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; wr_en = 1'b0; inpkt_end = 1'b0; din = 8'h00; word_full = 1'b0;
        #3;
        checks++;
        if ({word_out, range_info, word_id, word_list_end, word_wr_en, err_word_list, full} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: word=%h range=%h id=%0d end=%b vld=%b err=%b full=%b, required all 0",
                     word_out, range_info, word_id, word_list_end, word_wr_en, err_word_list, full);
        end
        do_reset();
    endtask

    task automatic test_single_word;
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h61, 1'b0); send_byte(8'h62, 1'b0);
        send_byte(8'h00, 1'b1);
        checks++;
        if (word_wr_en !== 1'b1 || full !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: vld=%b full=%b one cycle after last byte, required vld=1 full=1", word_wr_en, full);
        end
        expect_word("single_ab", 56'h3161, 8'h00, 16'd0, 1'b0);
        expect_word("single_dummy", 56'h0, 8'h00, 16'd1, 1'b1);
        checks++;
        if (word_wr_en !== 1'b0 || full !== 1'b0 || word_id !== 16'd0) begin
            errors++;
            $display("FAIL single_idle: vld=%b full=%b id=%0d, required 0 0 0", word_wr_en, full, word_id);
        end
    endtask

    task automatic test_full_length;
        logic [55:0] exp_w;
        exp_w = '0;
        for (int i = 0; i < 8; i++) exp_w[i*7 +: 7] = 7'(8'h61 + i);
        send_byte(8'h83, 1'b0); send_byte(8'h80, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h61 + i), i == 7);
        expect_word("full_len_word", exp_w, 8'h8B, 16'd0, 1'b0);
        expect_word("full_len_dummy", 56'h0, 8'h00, 16'd1, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [55:0] exp_w;
        word_full = 1'b1;
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h78, 1'b0); send_byte(8'h00, 1'b0);
        din = 8'h00; wr_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (word_wr_en !== 1'b1 || word_out !== 56'h78 || word_id !== 16'd0 || full !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle%0d: vld=%b word=%h id=%0d full=%b, required vld=1 word=78 id=0 full=1",
                         c, word_wr_en, word_out, word_id, full);
            end
            @(posedge CLK); #1;
        end
        wr_en = 1'b0; word_full = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (word_wr_en !== 1'b0 || word_id !== 16'd1 || full !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: vld=%b id=%0d full=%b, required vld=0 id=1 full=0", word_wr_en, word_id, full);
        end
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h79, 1'b0); send_byte(8'h00, 1'b1);
        expect_word("b2b_y", 56'h79, 8'h00, 16'd1, 1'b0);
        expect_word("b2b_dummy", 56'h0, 8'h00, 16'd2, 1'b1);
        // Next packet: an 8-char word followed by a zero that must be taken as a range byte.
        exp_w = '0;
        for (int i = 0; i < 8; i++) exp_w[i*7 +: 7] = 7'(8'h61 + i);
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h61 + i), 1'b0);
        expect_word("next_pkt_first", exp_w, 8'h00, 16'd0, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h7A, 1'b0); send_byte(8'h00, 1'b1);
        expect_word("zero_as_range", 56'h7A, 8'h00, 16'd1, 1'b0);
        expect_word("next_pkt_dummy", 56'h0, 8'h00, 16'd2, 1'b1);
    endtask

    task automatic test_error_range;
        send_byte(8'h88, 1'b0);
        din = 8'h00; wr_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (err_word_list !== 1'b1 || full !== 1'b1 || word_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL range_pos_err%0d: err=%b full=%b vld=%b, required 1 1 0", c, err_word_list, full, word_wr_en);
            end
            @(posedge CLK); #1;
        end
        do_reset();
        checks++;
        if (err_word_list !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: err=%b full=%b, required 0 0", err_word_list, full);
        end
    endtask

    task automatic test_error_char_and_end;
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'hC1, 1'b0);
        checks++;
        if (err_word_list !== 1'b1 || full !== 1'b1) begin
            errors++;
            $display("FAIL char_bit7_err: err=%b full=%b, required 1 1", err_word_list, full);
        end
        do_reset();
        send_byte(8'h00, 1'b1);
        checks++;
        if (err_word_list !== 1'b1 || full !== 1'b1) begin
            errors++;
            $display("FAIL range_end_err: err=%b full=%b, required 1 1", err_word_list, full);
        end
        do_reset();
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h61, 1'b1);
        checks++;
        if (err_word_list !== 1'b1 || word_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL char_end_err: err=%b vld=%b, required 1 0", err_word_list, word_wr_en);
        end
        do_reset();
    endtask

    task automatic test_reset_in_send;
        word_full = 1'b1;
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h61, 1'b0); send_byte(8'h00, 1'b1);
        checks++;
        if (word_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst_send: vld=%b, required 1", word_wr_en);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (word_wr_en !== 1'b0 || word_out !== 56'h0 || word_id !== 16'd0) begin
            errors++;
            $display("FAIL async_rst_send: vld=%b word=%h id=%0d, required 0 0 0", word_wr_en, word_out, word_id);
        end
        @(posedge CLK); #1;
        rst = 1'b0; word_full = 1'b0;
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h71, 1'b0); send_byte(8'h00, 1'b1);
        expect_word("post_rst_word", 56'h71, 8'h00, 16'd0, 1'b0);
        expect_word("post_rst_dummy", 56'h0, 8'h00, 16'd1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_length();
        test_back_to_back();
        test_error_range();
        test_error_char_and_end();
        test_reset_in_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
